// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit producing HI/LO for mult, multu, div and divu.
// Holds a stall request while an operation is in flight; supports flush abort.
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CntMax = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StSign, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    logic                 is_signed;
    logic [2*WIDTH-1:0]   a_ext, b_ext, product;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       rem_shift, diff;
    logic                 fits;

    // op[0] clear selects the signed variants (mult, div).
    assign is_signed = ~op[0];
    assign a_ext     = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    assign b_ext     = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    assign product   = a_ext * b_ext;
    assign abs_a     = (is_signed & a[WIDTH-1]) ? -a : a;
    assign abs_b     = (is_signed & b[WIDTH-1]) ? -b : b;

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign fits      = ~diff[WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    if (!op[1]) begin
                        prod_d  = product;
                        cnt_d   = CntW'(MUL_CYCLES);
                        state_d = StMul;
                    end else if (b == '0) begin
                        hi_d    = a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        quo_d     = abs_a;
                        rem_d     = '0;
                        dvs_d     = abs_b;
                        neg_d     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_d = is_signed & a[WIDTH-1];
                        cnt_d     = CntW'(WIDTH);
                        state_d   = StDiv;
                    end
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        hi_d    = prod_q[2*WIDTH-1:WIDTH];
                        lo_d    = prod_q[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = StDone;
                    end
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StSign;
                    end
                end
            end
            StSign: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    hi_d    = rem_neg_q ? -rem_q : rem_q;
                    lo_d    = neg_q ? -quo_q : quo_q;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == StMul) || (state_q == StDiv) || (state_q == StSign);
    assign done        = (state_q == StDone);
    assign stall_req   = rst & (busy | ((state_q == StIdle) & start & ~flush));
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a monitor
// pops and compares them whenever done is observed.
module tb_muldiv_unit;

    logic        clka;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cycle;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    muldiv_unit #(
        .WIDTH      (32),
        .MUL_CYCLES (1)
    ) dut (
        .clka        (clka),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .stall_req   (stall_req),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clka);
            if (rst && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cycle));
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                end
            end
        end
    end

    // Issue one op at cycle t, hold start through DONE, drop it at done+1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          input int lat);
        exp_t e;
        int   t;
        @(posedge clka); #1;
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        t     = cyc;
        e.hi = ehi; e.lo = elo; e.dbz = edbz; e.cycle = t + lat;
        sb.push_back(e);
        @(negedge clka);
        check("stall_accept", 64'(stall_req), 64'd1);
        for (int k = 1; k < lat; k++) begin
            @(posedge clka); #1;
            // Operands are only sampled in the accepting cycle.
            a = $urandom;
            b = $urandom;
            @(negedge clka);
            check("stall_busy", 64'(stall_req), 64'd1);
            check("busy_inflight", 64'(busy), 64'd1);
        end
        @(posedge clka); #1;
        @(negedge clka);
        check("stall_at_done", 64'(stall_req), 64'd0);
        check("busy_at_done", 64'(busy), 64'd0);
        @(posedge clka); #1;
        start = 1'b0;
        @(negedge clka);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b1;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        flush = 1'b0;
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        start = 1'b0;
        @(negedge clka);
        rst = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 2);
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 34);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 34);
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 2);

        // Flush mid-divide: no done, results untouched.
        @(posedge clka); #1;
        start = 1'b1;
        op    = 2'b10;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        repeat (10) @(posedge clka);
        #1;
        flush = 1'b1;
        @(negedge clka);
        check("flush_cycle_stall", 64'(stall_req), 64'd1);
        @(posedge clka); #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clka);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_stall", 64'(stall_req), 64'd0);
        repeat (40) @(posedge clka);
        #1;
        check("flush_hi_kept", 64'(hi), 64'h2);
        check("flush_lo_kept", 64'(lo), 64'hFFFF_FFFA);

        // Reset mid-divide: outputs clear immediately, no done afterwards.
        @(posedge clka); #1;
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd7;
        repeat (5) @(posedge clka);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_stall", 64'(stall_req), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clka);
        start = 1'b0;
        rst   = 1'b1;
        repeat (45) @(posedge clka);
        #1;
        check("midrst_busy_after", 64'(busy), 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core. It sits beside the execute-stage ALU and produces the HI/LO results for mult, multu, div and divu. While an operation is in flight it raises a stall request that the hazard logic merges with the instruction and data stalls. Width and multiply latency are parameters. The unit adds flush abort, divide-by-zero detection and a registered completion pulse.

## Interface
- WIDTH, 32: operand width; HI and LO are WIDTH bits each.
- MUL_CYCLES, 1: cycles spent in MUL after the start cycle; minimum 1.
- clka  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level request from the E-stage instruction.
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  multiplicand or dividend (rs).
- b  in  WIDTH  multiplier or divisor (rt).
- flush  in  1  abort the operation in flight.
- busy  out  1  high in MUL, DIV and SIGN.
- done  out  1  high for exactly the one cycle spent in DONE.
- stall_req  out  1  pipeline stall request.
- hi  out  WIDTH  product high half, or remainder.
- lo  out  WIDTH  product low half, or quotient.
- div_by_zero  out  1  set if the last completed operation was a divide with b==0.

## Operation
- States: IDLE, MUL, DIV, SIGN, DONE.
- **IDLE, accepting a request:** start=1 and flush=0 latches the op and operands.
  - mult/multu: the 2*WIDTH product is registered, the counter is loaded with MUL_CYCLES, and the state goes to MUL.
  - div/divu with b!=0: |a| and |b| are latched (divu uses them raw), the sign flags are recorded, and the state goes to DIV.
  - div/divu with b==0: the state goes straight to DONE with hi=a, lo={WIDTH{1}} and div_by_zero=1.
- **MUL:** the counter decrements each cycle. When it reaches 1, hi/lo are loaded from the product and the state goes to DONE.
- **DIV:** radix-2 restoring division, one quotient bit per cycle, WIDTH cycles, then SIGN.
- **SIGN:** fixes the result signs, then goes to DONE.
  - The quotient is negated when the op is signed and the operand signs differ.
  - The remainder takes the sign of the dividend.
  - hi=remainder, lo=quotient are loaded on the edge leaving SIGN.
  - Signed MIN/-1 yields lo=MIN, hi=0 through the natural wraparound; no trap.
- **DONE:** done=1. start is ignored here, because the same E-stage instruction is still presenting it. The state always returns to IDLE.
- div_by_zero is rewritten on every entry to DONE: 1 only for a zero divisor, otherwise 0.
- hi, lo and div_by_zero hold their values between completions.
- start while busy is ignored. op, a and b are sampled only in the accepting cycle.
- **Flush:**
  - flush=1 in MUL, DIV or SIGN sends the state to IDLE on the next edge.
  - hi, lo and div_by_zero are left unchanged, and done never pulses for the aborted op.
  - flush=1 in IDLE suppresses acceptance of start.
  - flush in DONE has no effect; the results are already committed.
- stall_req = busy | (state==IDLE & start & ~flush). It is 0 in DONE, so the pipeline advances at the end of the done cycle.

## Timing
- Reset (rst low, asynchronous, immediate): state=IDLE, hi=0, lo=0, done=0, busy=0, div_by_zero=0, counter=0. stall_req is forced to 0 while rst is low.
- Requests are accepted in cycle t.
- Multiply: MUL occupies t+1..t+MUL_CYCLES, and done plus valid hi/lo appear at t+MUL_CYCLES+1. With the default, done is at t+2.
- Divide, nonzero divisor: DIV occupies t+1..t+WIDTH, SIGN is at t+WIDTH+1, and done is at t+WIDTH+2. With the default, done is at t+34.
- Divide by zero: done at t+1.
- stall_req is high from cycle t through the cycle before done.
- Back-to-back operations: the earliest next acceptance is done+1 (IDLE).
- Reset asserted mid-operation: the op is lost, and outputs take their reset values in the same cycle.

## Test plan
- **mult/multu**, WIDTH=32, MUL_CYCLES=1, a=0xFFFFFFFE, b=3, start at cycle 0:
  - mult -> done at cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu -> hi=0x00000002, lo=0xFFFFFFFA.
  - stall_req is high in cycles 0-1 and low in cycle 2.
- **div/divu**, a=0xFFFFFFF9, b=2:
  - div -> done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu -> lo=0x7FFFFFFC, hi=0x00000001, div_by_zero=0.
- **Divide by zero:** divu a=0x12345678, b=0 -> done at cycle 1, hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1. The next good divide clears div_by_zero.
- **Signed overflow:** div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- **Flush mid-divide:**
  - Complete a multu so hi/lo=0x2/0xFFFFFFFA.
  - Start div, then assert flush at cycle 10 -> IDLE at cycle 11, and busy and stall_req drop at cycle 11.
  - No done pulse occurs, and hi/lo are still 0x2/0xFFFFFFFA.
- **Start held and reset:**
  - Hold start high through DONE -> no retrigger, busy stays 0 at done+1.
  - Then drop start, start a div, and assert rst low at cycle 5 -> hi=lo=0, busy=0 and stall_req=0 immediately. No done follows release.
